// File: rtl/di_initiator_if.sv
// Command, stream and device-interface bus bundle for di_initiator.
// master = the initiator; slave = whoever drives commands and plays the responder.
interface di_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_term;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_len;

    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;

    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;

    logic        busy;
    logic        done;
    logic [15:0] status;

    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [31:0] di_len;
    logic        di_read_mode;
    logic        di_read_req;
    logic        di_read;
    logic        di_write_mode;
    logic        di_write;
    logic [15:0] di_reg_datai;
    logic [15:0] di_reg_datao;
    logic        di_read_rdy;
    logic        di_write_rdy;
    logic [15:0] di_transfer_status;

    modport master (
        input  cmd_valid, cmd_write, cmd_term, cmd_addr, cmd_len,
        input  wr_data, wr_valid, rd_ready,
        input  di_reg_datao, di_read_rdy, di_write_rdy, di_transfer_status,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, status,
        output di_term_addr, di_reg_addr, di_len,
        output di_read_mode, di_read_req, di_read, di_write_mode, di_write,
        output di_reg_datai
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_term, cmd_addr, cmd_len,
        output wr_data, wr_valid, rd_ready,
        output di_reg_datao, di_read_rdy, di_write_rdy, di_transfer_status,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, status,
        input  di_term_addr, di_reg_addr, di_len,
        input  di_read_mode, di_read_req, di_read, di_write_mode, di_write,
        input  di_reg_datai
    );
endinterface

// File: rtl/di_initiator.sv
// Device-interface bus master: runs one terminal transfer per command,
// buffers read words in a 2-entry FIFO and reports the responder status.
module di_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned MODE_GAP       = 1
) (
    input logic ifclk,
    input logic resetb,
    di_initiator_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (MODE_GAP > 1) ? $clog2(MODE_GAP) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(MODE_GAP - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        XFER   = 2'd2,
        STATUS = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic        dir;
    logic [31:0] remaining;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tmo_cnt;
    logic        abort;
    logic        done_q;
    logic [15:0] status_q;
    logic [15:0] term_q;
    logic [31:0] addr_q;
    logic [31:0] len_q;

    logic [1:0][15:0] fifo_mem;
    logic        fifo_head;
    logic [1:0]  fifo_cnt;

    logic        in_xfer;
    logic        wr_go;
    logic        rd_req;
    logic        rd_go;
    logic        strobe;
    logic        last_word;
    logic        tmo_hit;
    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] words_in;

    // Round bytes up to 16-bit words without needing a 33-bit adder.
    assign words_in  = {1'b0, bus.cmd_len[31:1]} + {31'd0, bus.cmd_len[0]};

    assign in_xfer   = (state == XFER);
    assign wr_go     = in_xfer & dir & bus.wr_valid & bus.di_write_rdy;
    assign rd_req    = in_xfer & ~dir & (fifo_cnt < 2'd2) & (remaining != 32'd0);
    assign rd_go     = rd_req & bus.di_read_rdy;
    assign strobe    = wr_go | rd_go;
    assign last_word = strobe & (remaining == 32'd1);
    assign tmo_hit   = in_xfer & ~strobe & (tmo_cnt == TMO_LAST);

    // A read must not start while an earlier read's words are still queued.
    assign bus.cmd_ready = (state == IDLE) & (bus.cmd_write | (fifo_cnt == 2'd0));
    assign accept        = bus.cmd_valid & bus.cmd_ready;

    assign bus.busy          = (state != IDLE);
    assign bus.done          = done_q;
    assign bus.status        = status_q;
    assign bus.di_term_addr  = term_q;
    assign bus.di_reg_addr   = addr_q;
    assign bus.di_len        = len_q;
    assign bus.di_write_mode = (state != IDLE) & dir;
    assign bus.di_read_mode  = (state != IDLE) & ~dir;
    assign bus.di_write      = wr_go;
    assign bus.wr_ready      = wr_go;
    assign bus.di_read_req   = rd_req;
    assign bus.di_read       = rd_go;
    assign bus.di_reg_datai  = (in_xfer & dir) ? bus.wr_data : 16'h0000;

    assign push         = rd_go;
    assign pop          = bus.rd_valid & bus.rd_ready;
    assign bus.rd_valid = (fifo_cnt != 2'd0);
    assign bus.rd_data  = fifo_mem[fifo_head];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SETUP;
            SETUP:   if (gap_cnt == GAP_LAST) state_nx = (remaining == 32'd0) ? STATUS : XFER;
            XFER:    if (last_word || tmo_hit) state_nx = STATUS;
            STATUS:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            dir       <= 1'b0;
            remaining <= 32'd0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
            abort     <= 1'b0;
            done_q    <= 1'b0;
            status_q  <= 16'h0000;
            term_q    <= 16'h0000;
            addr_q    <= 32'd0;
            len_q     <= 32'd0;
        end else begin
            state  <= state_nx;
            done_q <= (state == STATUS);
            if (accept) begin
                dir       <= bus.cmd_write;
                term_q    <= bus.cmd_term;
                addr_q    <= bus.cmd_addr;
                len_q     <= bus.cmd_len;
                remaining <= words_in;
                gap_cnt   <= '0;
                tmo_cnt   <= '0;
                abort     <= 1'b0;
            end
            if (state == SETUP) gap_cnt <= gap_cnt + GW'(1);
            if (in_xfer) begin
                if (strobe) begin
                    remaining <= remaining - 32'd1;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
                if (tmo_hit) abort <= 1'b1;
            end
            if (state == STATUS) status_q <= abort ? 16'hFFFE : bus.di_transfer_status;
        end
    end

    // Push lands behind the head; at count 1 with a pop the new word becomes the head.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            fifo_mem  <= '0;
            fifo_head <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            if (push) fifo_mem[fifo_head ^ fifo_cnt[0]] <= bus.di_reg_datao;
            if (pop)  fifo_head <= ~fifo_head;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_di_initiator.sv
// Randomized bench for di_initiator: per-transfer word/timing expectations
// are computed from byte length, source queues and the cycle rules.
module tb_di_initiator;
    localparam int TMO = 16;

    logic ifclk = 1'b0;
    logic resetb;
    always #5 ifclk = ~ifclk;

    di_initiator_if bus();

    di_initiator #(.TIMEOUT_CYCLES(TMO), .MODE_GAP(1)) dut (
        .ifclk (ifclk),
        .resetb(resetb),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] wsrc[$];
    logic [15:0] rsrc[$];
    logic [15:0] got_w[$];
    logic [15:0] got_r[$];
    int nwr, nrd, nstrobe, first_strobe, last_strobe, done_cyc, ndone, viol, mode_err;

    // Drives one transfer cycle by cycle; cycle 0 is the one presenting cmd_valid.
    task automatic run_xfer(input bit issue, input bit wr, input logic [15:0] term,
                            input logic [31:0] addr, input logic [31:0] len,
                            input int p_val, input int p_rdy, input int p_rd, input int max_cyc);
        bit acc;
        if (issue) begin
            got_w.delete(); got_r.delete();
            nwr = 0; nrd = 0; nstrobe = 0; first_strobe = -1; last_strobe = -1;
            done_cyc = -1; ndone = 0; viol = 0; mode_err = 0;
            bus.cmd_valid = 1'b1;
            bus.cmd_write = wr;
            bus.cmd_term  = term;
            bus.cmd_addr  = addr;
            bus.cmd_len   = len;
        end
        for (int c = 0; c < max_cyc; c++) begin
            bus.wr_valid     = wr && (int'($urandom_range(99)) < p_val);
            bus.wr_data      = (nwr < wsrc.size()) ? wsrc[nwr] : 16'h0000;
            bus.di_write_rdy = int'($urandom_range(99)) < p_rdy;
            bus.di_read_rdy  = int'($urandom_range(99)) < p_rdy;
            bus.rd_ready     = int'($urandom_range(99)) < p_rd;
            bus.di_reg_datao = (nrd < rsrc.size()) ? rsrc[nrd] : 16'h0000;
            @(negedge ifclk);
            acc = bus.cmd_valid && bus.cmd_ready;
            if (bus.di_write || bus.di_read) begin
                nstrobe++;
                if (first_strobe < 0) first_strobe = c;
                last_strobe = c;
            end
            if (bus.di_write) begin got_w.push_back(bus.di_reg_datai); nwr++; end
            if (bus.di_read) nrd++;
            if (bus.rd_valid && bus.rd_ready) got_r.push_back(bus.rd_data);
            if (bus.di_read && bus.di_write) viol++;
            if ((bus.di_read || bus.di_write) && !bus.busy) viol++;
            if (bus.busy && (bus.di_write_mode !== wr || bus.di_read_mode !== !wr ||
                bus.di_len !== len || bus.di_reg_addr !== addr || bus.di_term_addr !== term))
                mode_err++;
            if (bus.done) begin ndone++; done_cyc = c; end
            @(posedge ifclk); #1;
            if (acc) bus.cmd_valid = 1'b0;
            if (ndone > 0 && (wr || !bus.rd_valid)) break;
        end
        bus.cmd_valid = 1'b0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        bus.di_write_rdy = 1'b0; bus.di_read_rdy = 1'b0;
    endtask

    task automatic test_reset;
        resetb = 1'b0;
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_term = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
        bus.wr_data = 0; bus.wr_valid = 0; bus.rd_ready = 0;
        bus.di_reg_datao = 0; bus.di_read_rdy = 0; bus.di_write_rdy = 0; bus.di_transfer_status = 0;
        @(posedge ifclk); @(posedge ifclk); #1;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
        total++; if ({bus.busy, bus.done, bus.rd_valid} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.done, bus.rd_valid}); end
        total++; if (bus.status !== 16'h0) begin bad++; $display("FAIL reset_status got=%h exp=0000", bus.status); end
        total++; if ({bus.di_read_mode, bus.di_read_req, bus.di_read, bus.di_write_mode, bus.di_write} !== 5'b0) begin
            bad++; $display("FAIL reset_di_ctl got=%b exp=00000", {bus.di_read_mode, bus.di_read_req, bus.di_read, bus.di_write_mode, bus.di_write}); end
        total++; if ({bus.di_term_addr, bus.di_reg_addr, bus.di_len, bus.di_reg_datai} !== 96'h0) begin
            bad++; $display("FAIL reset_di_fields got=%h exp=0", {bus.di_term_addr, bus.di_reg_addr, bus.di_len, bus.di_reg_datai}); end
        resetb = 1'b1;
        @(posedge ifclk); #1;
    endtask

    task automatic test_write_basic;
        wsrc = '{16'h1111, 16'h2222, 16'h3333};
        bus.di_transfer_status = 16'h0000;
        run_xfer(1, 1, 16'h0005, 32'h10, 32'd6, 100, 100, 0, 30);
        total++; if (nstrobe !== 3 || first_strobe !== 2 || last_strobe !== 4) begin
            bad++; $display("FAIL wr_basic_strobes got=%0d@%0d..%0d exp=3@2..4", nstrobe, first_strobe, last_strobe); end
        for (int i = 0; i < 3; i++) begin
            total++; if (i >= got_w.size() || got_w[i] !== wsrc[i]) begin
                bad++; $display("FAIL wr_basic_data[%0d] got=%h exp=%h", i, (i < got_w.size()) ? got_w[i] : 16'hxxxx, wsrc[i]); end
        end
        total++; if (done_cyc !== 6 || ndone !== 1) begin bad++; $display("FAIL wr_basic_done got=%0d/%0d exp=6/1", done_cyc, ndone); end
        total++; if (bus.status !== 16'h0000) begin bad++; $display("FAIL wr_basic_status got=%h exp=0000", bus.status); end
        total++; if (mode_err !== 0 || viol !== 0) begin bad++; $display("FAIL wr_basic_bus got=%0d/%0d exp=0/0", mode_err, viol); end
    endtask

    task automatic test_read_backpressure;
        rsrc = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        bus.di_transfer_status = 16'h0000;
        run_xfer(1, 0, 16'h0007, 32'h20, 32'd8, 100, 100, 0, 8);
        total++; if (nrd !== 2 || got_r.size() !== 0) begin bad++; $display("FAIL rd_bp_captured got=%0d/%0d exp=2/0", nrd, got_r.size()); end
        total++; if (bus.di_read_req !== 1'b0 || bus.rd_valid !== 1'b1 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL rd_bp_stall got=%b%b%b exp=011", bus.di_read_req, bus.rd_valid, bus.busy); end
        total++; if (bus.rd_data !== 16'h00A0) begin bad++; $display("FAIL rd_bp_head got=%h exp=00a0", bus.rd_data); end
        run_xfer(0, 0, 16'h0007, 32'h20, 32'd8, 100, 100, 100, 40);
        for (int i = 0; i < 4; i++) begin
            total++; if (i >= got_r.size() || got_r[i] !== rsrc[i]) begin
                bad++; $display("FAIL rd_bp_data[%0d] got=%h exp=%h", i, (i < got_r.size()) ? got_r[i] : 16'hxxxx, rsrc[i]); end
        end
        total++; if (nrd !== 4 || ndone !== 1 || bus.status !== 16'h0000) begin
            bad++; $display("FAIL rd_bp_end got=%0d/%0d/%h exp=4/1/0000", nrd, ndone, bus.status); end
    endtask

    task automatic test_len_zero;
        bus.di_transfer_status = 16'h1234;
        run_xfer(1, 0, 16'h0002, 32'h40, 32'd0, 100, 100, 100, 20);
        total++; if (nstrobe !== 0) begin bad++; $display("FAIL len0_strobes got=%0d exp=0", nstrobe); end
        total++; if (done_cyc !== 3) begin bad++; $display("FAIL len0_done got=%0d exp=3", done_cyc); end
        total++; if (bus.status !== 16'h1234) begin bad++; $display("FAIL len0_status got=%h exp=1234", bus.status); end
    endtask

    task automatic test_timeout;
        wsrc = '{16'hBEEF, 16'hCAFE};
        bus.di_transfer_status = 16'h0000;
        // XFER opens at cycle 2, runs TMO strobe-less cycles, one STATUS cycle, then done.
        run_xfer(1, 1, 16'h0009, 32'h80, 32'd4, 100, 0, 0, 60);
        total++; if (nstrobe !== 0) begin bad++; $display("FAIL tmo_strobes got=%0d exp=0", nstrobe); end
        total++; if (done_cyc !== 2 + TMO + 1 || ndone !== 1) begin bad++; $display("FAIL tmo_done got=%0d/%0d exp=%0d/1", done_cyc, ndone, 2 + TMO + 1); end
        total++; if (bus.status !== 16'hFFFE) begin bad++; $display("FAIL tmo_status got=%h exp=fffe", bus.status); end
    endtask

    task automatic test_odd_len;
        wsrc = '{16'h0101, 16'h0202, 16'h0303};
        bus.di_transfer_status = 16'hFFFF;
        run_xfer(1, 1, 16'h000A, 32'h100, 32'd5, 100, 100, 0, 30);
        total++; if (nstrobe !== 3) begin bad++; $display("FAIL odd_strobes got=%0d exp=3", nstrobe); end
        total++; if (mode_err !== 0 || bus.di_len !== 32'd5) begin bad++; $display("FAIL odd_di_len got=%0d err=%0d exp=5", bus.di_len, mode_err); end
        total++; if (bus.status !== 16'hFFFF) begin bad++; $display("FAIL odd_status got=%h exp=ffff", bus.status); end
        total++; if (got_w.size() != 3 || got_w[2] !== 16'h0303) begin bad++; $display("FAIL odd_last_word got_n=%0d exp=3", got_w.size()); end
    endtask

    task automatic test_reset_mid;
        int  seen = 0;
        int  dn = 0;
        bit  acc = 0;
        wsrc = '{16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04};
        bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_term = 16'h0033;
        bus.cmd_addr = 32'h1234; bus.cmd_len = 32'd8;
        bus.wr_valid = 1; bus.di_write_rdy = 1;
        for (int c = 0; c < 10 && seen < 2; c++) begin
            bus.wr_data = wsrc[seen];
            @(negedge ifclk);
            if (bus.cmd_valid && bus.cmd_ready) acc = 1;
            if (bus.di_write) seen++;
            if (seen < 2) begin @(posedge ifclk); #1; if (acc) bus.cmd_valid = 0; end
        end
        bus.cmd_valid = 0;
        total++; if (seen !== 2) begin bad++; $display("FAIL rst_mid_pre got=%0d exp=2", seen); end
        resetb = 1'b0;
        #1;
        total++; if ({bus.di_write_mode, bus.di_write, bus.busy} !== 3'b000) begin
            bad++; $display("FAIL rst_mid_ctl got=%b exp=000", {bus.di_write_mode, bus.di_write, bus.busy}); end
        total++; if ({bus.di_term_addr, bus.di_reg_addr, bus.di_len, bus.di_reg_datai} !== 96'h0) begin
            bad++; $display("FAIL rst_mid_fields got=%h exp=0", {bus.di_term_addr, bus.di_reg_addr, bus.di_len, bus.di_reg_datai}); end
        bus.wr_valid = 0; bus.di_write_rdy = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge ifclk);
            if (bus.done) dn++;
            @(posedge ifclk); #1;
            if (c == 2) resetb = 1'b1;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL rst_mid_done got=%0d exp=0", dn); end
        wsrc = '{16'h7001, 16'h7002};
        bus.di_transfer_status = 16'h0042;
        run_xfer(1, 1, 16'h0033, 32'h1234, 32'd4, 100, 100, 0, 30);
        total++; if (got_w.size() != 2 || got_w[0] !== 16'h7001 || got_w[1] !== 16'h7002) begin
            bad++; $display("FAIL rst_mid_after got_n=%0d exp=2 words 7001,7002", got_w.size()); end
        total++; if (ndone !== 1 || bus.status !== 16'h0042) begin bad++; $display("FAIL rst_mid_after_status got=%0d/%h exp=1/0042", ndone, bus.status); end
    endtask

    task automatic test_random(input bit wr, input int iters);
        for (int it = 0; it < iters; it++) begin
            logic [31:0] len;
            int words;
            logic [15:0] st;
            len   = 32'($urandom_range(41));
            words = int'((64'(len) + 64'd1) / 64'd2);
            st    = 16'($urandom);
            wsrc.delete(); rsrc.delete();
            for (int i = 0; i < words; i++) begin
                wsrc.push_back(16'($urandom));
                rsrc.push_back(16'($urandom));
            end
            bus.di_transfer_status = st;
            run_xfer(1, wr, 16'($urandom), $urandom, len, 85, 85, 70, 400);
            total++; if (nstrobe !== words || ndone !== 1) begin
                bad++; $display("FAIL rand%0d_%0d_count got=%0d/%0d exp=%0d/1", wr, it, nstrobe, ndone, words); end
            for (int i = 0; i < words; i++) begin
                logic [15:0] g;
                if (wr) g = (i < got_w.size()) ? got_w[i] : 16'hxxxx;
                else    g = (i < got_r.size()) ? got_r[i] : 16'hxxxx;
                total++; if (g !== (wr ? wsrc[i] : rsrc[i])) begin
                    bad++; $display("FAIL rand%0d_%0d_data[%0d] got=%h exp=%h", wr, it, i, g, wr ? wsrc[i] : rsrc[i]); end
            end
            total++; if (done_cyc !== ((words == 0) ? 3 : last_strobe + 2)) begin
                bad++; $display("FAIL rand%0d_%0d_done got=%0d exp=%0d", wr, it, done_cyc, (words == 0) ? 3 : last_strobe + 2); end
            total++; if (bus.status !== st) begin bad++; $display("FAIL rand%0d_%0d_status got=%h exp=%h", wr, it, bus.status, st); end
            total++; if (mode_err !== 0 || viol !== 0 || bus.rd_valid !== 1'b0) begin
                bad++; $display("FAIL rand%0d_%0d_bus got=%0d/%0d/%b exp=0/0/0", wr, it, mode_err, viol, bus.rd_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_backpressure();
        test_len_zero();
        test_timeout();
        test_odd_len();
        test_reset_mid();
        test_random(1'b1, 6);
        test_random(1'b0, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
